// File: rtl/mips_core_pkg.sv
// Shared sizes, index types and the commit FSM encoding for the OoO core.
package mips_core_pkg;
  localparam int AL_SIZE  = 32;
  localparam int LSQ_SIZE = 8;
  localparam int BR_SIZE  = 4;
  localparam int FL_SIZE  = 32;
  localparam int PREG_W   = 6;

  localparam int AL_W  = $clog2(AL_SIZE);
  localparam int LSQ_W = $clog2(LSQ_SIZE);
  localparam int BR_W  = $clog2(BR_SIZE);
  localparam int FL_W  = $clog2(FL_SIZE);

  typedef enum logic {IDLE = 1'b0, ST_WAIT = 1'b1} commit_fsm_e;

  typedef logic [AL_W-1:0]   al_idx_t;
  typedef logic [LSQ_W-1:0]  lsq_idx_t;
  typedef logic [BR_W-1:0]   br_idx_t;
  typedef logic [FL_W-1:0]   fl_idx_t;
  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/commit_retire_unit_wrap_ptr.sv
// Mod-N pointer (N a power of 2) with increment enable; wraps by natural overflow.
module wrap_ptr #(
  parameter int N = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_inc,
  output logic [$clog2(N)-1:0] o_ptr
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + ONE;
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/commit_retire_unit.sv
// In-order retirement from the active-list head, one instruction per cycle.
// Stores hold in ST_WAIT with store_req up until the D-cache acks the write.
module commit_retire_unit
  import mips_core_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [AL_SIZE-1:0]              i_al_occupied,
  input  logic [AL_SIZE-1:0]              i_ready_to_commit,
  input  logic [AL_SIZE-1:0]              i_is_branch,
  input  logic [AL_SIZE-1:0]              i_is_load,
  input  logic [AL_SIZE-1:0]              i_is_store,
  input  logic [AL_SIZE-1:0]              i_uses_rw,
  input  logic [AL_SIZE-1:0][PREG_W-1:0]  i_reclaim_list,
  input  logic                            i_branch_miss,
  input  logic                            i_store_ack,
  output logic                            o_store_req,
  output logic                            o_commit_valid,
  output al_idx_t                         o_commit_idx,
  output logic                            o_branch_done,
  output logic                            o_load_done,
  output logic                            o_store_done,
  output logic                            o_free_we,
  output preg_t                           o_free_reg,
  output al_idx_t                         o_oldest_inst_pointer,
  output br_idx_t                         o_branch_read_pointer,
  output lsq_idx_t                        o_load_commit_pointer,
  output lsq_idx_t                        o_store_commit_pointer,
  output fl_idx_t                         o_free_tail_pointer,
  output logic [31:0]                     o_commit_count
);
  commit_fsm_e r_state;
  logic [31:0] r_commit_count;
  al_idx_t     w_head;
  logic        w_head_ok;
  logic        w_retire;
  logic        w_unused;

  // The head is always older than any mispredicted branch, so recovery never stalls retirement.
  assign w_unused  = i_branch_miss;

  assign w_head    = o_oldest_inst_pointer;
  assign w_head_ok = i_al_occupied[w_head] & i_ready_to_commit[w_head];
  // Gated by reset so no pulse leaks out while the pointers are being cleared.
  assign w_retire  = i_rst_n & ((r_state == ST_WAIT) ? i_store_ack
                                                     : (w_head_ok & ~i_is_store[w_head]));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_head_ok && i_is_store[w_head]) r_state <= ST_WAIT;
        ST_WAIT: if (i_store_ack)                     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_commit_count <= '0;
    else if (w_retire) r_commit_count <= r_commit_count + 32'd1;
  end

  assign o_store_req    = (r_state == ST_WAIT);
  assign o_commit_valid = w_retire;
  assign o_commit_idx   = w_head;
  assign o_branch_done  = w_retire & i_is_branch[w_head];
  assign o_load_done    = w_retire & i_is_load[w_head];
  assign o_store_done   = w_retire & i_is_store[w_head];
  assign o_free_we      = w_retire & i_uses_rw[w_head];
  assign o_free_reg     = i_reclaim_list[w_head];
  assign o_commit_count = r_commit_count;

  wrap_ptr #(.N(AL_SIZE)) u_oldest (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_retire), .o_ptr(o_oldest_inst_pointer));
  wrap_ptr #(.N(BR_SIZE)) u_br (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(o_branch_done), .o_ptr(o_branch_read_pointer));
  wrap_ptr #(.N(LSQ_SIZE)) u_lq (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(o_load_done), .o_ptr(o_load_commit_pointer));
  wrap_ptr #(.N(LSQ_SIZE)) u_sq (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(o_store_done), .o_ptr(o_store_commit_pointer));
  wrap_ptr #(.N(FL_SIZE)) u_fl (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(o_free_we), .o_ptr(o_free_tail_pointer));
endmodule

// File: tb/tb_commit_retire_unit.sv
// Directed scenarios plus randomized traffic against a pointer/counter model of in-order retirement.
module tb_commit_retire_unit;
  import mips_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] occ, rdy, isb, isl, iss, urw;
  logic [31:0][5:0] recl;
  logic bmiss, ack;

  logic sreq, cv, bd, ld, sd, fwe;
  al_idx_t cidx, oldest;
  preg_t freg;
  br_idx_t brp;
  lsq_idx_t lqp, sqp;
  fl_idx_t ftp;
  logic [31:0] ccnt;

  commit_retire_unit dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_al_occupied(occ), .i_ready_to_commit(rdy),
    .i_is_branch(isb), .i_is_load(isl), .i_is_store(iss), .i_uses_rw(urw),
    .i_reclaim_list(recl), .i_branch_miss(bmiss), .i_store_ack(ack),
    .o_store_req(sreq), .o_commit_valid(cv), .o_commit_idx(cidx),
    .o_branch_done(bd), .o_load_done(ld), .o_store_done(sd),
    .o_free_we(fwe), .o_free_reg(freg),
    .o_oldest_inst_pointer(oldest), .o_branch_read_pointer(brp),
    .o_load_commit_pointer(lqp), .o_store_commit_pointer(sqp),
    .o_free_tail_pointer(ftp), .o_commit_count(ccnt));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: retirement as counters over plain ints, plus a "store outstanding" flag.
  int m_head, m_br, m_lq, m_sq, m_ft;
  int unsigned m_cnt;
  bit m_wait;

  always @(negedge clk) begin
    int h;
    bit ret;
    if (!rst_n) begin
      m_head = 0; m_br = 0; m_lq = 0; m_sq = 0; m_ft = 0; m_cnt = 0; m_wait = 0;
      chk("rst_pulses", {cv, bd, ld, sd, fwe, sreq}, 0);
      chk("rst_ptrs", {oldest, brp, lqp, sqp, ftp}, 0);
      chk("rst_count", ccnt, 0);
    end else begin
      h = m_head;
      ret = m_wait ? ack : (occ[h] && rdy[h] && !iss[h]);
      chk("commit_valid", cv, ret);
      chk("store_req", sreq, m_wait);
      chk("branch_done", bd, ret && isb[h]);
      chk("load_done", ld, ret && isl[h]);
      chk("store_done", sd, ret && iss[h]);
      chk("free_we", fwe, ret && urw[h]);
      if (ret) chk("commit_idx", cidx, h);
      if (ret && urw[h]) chk("free_reg", freg, recl[h]);
      chk("oldest_ptr", oldest, m_head);
      chk("branch_ptr", brp, m_br);
      chk("load_ptr", lqp, m_lq);
      chk("store_ptr", sqp, m_sq);
      chk("free_tail", ftp, m_ft);
      chk("commit_count", ccnt, m_cnt);
      if (m_wait) begin
        if (ack) m_wait = 0;
      end else if (occ[h] && rdy[h] && iss[h]) begin
        m_wait = 1;
      end
      if (ret) begin
        m_head = (m_head + 1) % AL_SIZE;
        if (isb[h]) m_br = (m_br + 1) % BR_SIZE;
        if (isl[h]) m_lq = (m_lq + 1) % LSQ_SIZE;
        if (iss[h]) m_sq = (m_sq + 1) % LSQ_SIZE;
        if (urw[h]) m_ft = (m_ft + 1) % FL_SIZE;
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic clear_al();
    occ = '0; rdy = '0; isb = '0; isl = '0; iss = '0; urw = '0; recl = '0;
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    bit reached;
    clear_al(); bmiss = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t0_reset_oldest", oldest, 0);
    chk("t0_reset_count", ccnt, 0);
    chk("t0_reset_sreq", sreq, 0);

    // 1: three ALU ops with reclaim 7,8,9
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      occ[i] = 1; rdy[i] = 1; urw[i] = 1; recl[i] = 6'(7 + i);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_valid", cv, 1);
      chk("t1_free_reg", freg, 7 + i);
      chk("t1_free_tail", ftp, i);
    end
    @(negedge clk);
    chk("t1_idle", cv, 0);
    chk("t1_oldest", oldest, 3);
    chk("t1_free_tail_end", ftp, 3);
    chk("t1_count", ccnt, 3);

    // 2: three loads; third retires at load pointer 2
    drive_edge();
    for (int i = 3; i < 6; i++) begin occ[i] = 1; rdy[i] = 1; isl[i] = 1; end
    repeat (3) @(negedge clk);
    chk("t2_load_done", ld, 1);
    chk("t2_load_ptr_pre", lqp, 2);
    @(negedge clk);
    chk("t2_load_ptr_post", lqp, 3);

    // 3: store at 6 acked after 4 wait cycles, ALU at 7 behind it
    drive_edge();
    occ[6] = 1; rdy[6] = 1; iss[6] = 1;
    occ[7] = 1; rdy[7] = 1; urw[7] = 1; recl[7] = 6'd20;
    @(negedge clk);
    chk("t3_idle_sreq", sreq, 0);
    chk("t3_idle_valid", cv, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_wait_sreq", sreq, 1);
      chk("t3_wait_no_retire", cv, 0);
    end
    drive_edge(); ack = 1;
    @(negedge clk);
    chk("t3_ack_sreq", sreq, 1);
    chk("t3_store_done", sd, 1);
    chk("t3_store_idx", cidx, 6);
    drive_edge(); ack = 0;
    @(negedge clk);
    chk("t3_alu_valid", cv, 1);
    chk("t3_alu_idx", cidx, 7);
    chk("t3_store_ptr", sqp, 1);

    // 5: branch_miss held high through a store wait and an ALU retire
    drive_edge();
    bmiss = 1;
    occ[8] = 1; rdy[8] = 1; iss[8] = 1;
    occ[9] = 1; rdy[9] = 1; urw[9] = 1; recl[9] = 6'd21;
    @(negedge clk);
    @(negedge clk);
    chk("t5_sreq", sreq, 1);
    drive_edge(); ack = 1;
    @(negedge clk);
    chk("t5_store_done", sd, 1);
    drive_edge(); ack = 0;
    @(negedge clk);
    chk("t5_alu_valid", cv, 1);
    chk("t5_free_reg", freg, 21);
    drive_edge(); bmiss = 0;

    // 4: branches at 10..12 push branch pointer to 3, branch at 31 wraps both
    clear_al();
    for (int i = 10; i < 32; i++) begin occ[i] = 1; rdy[i] = 1; end
    isb[10] = 1; isb[11] = 1; isb[12] = 1; isb[31] = 1;
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(negedge clk);
      if (oldest == 31) reached = 1;
    end
    chk("t4_reached_31", reached, 1);
    chk("t4_branch_done", bd, 1);
    chk("t4_br_ptr_pre", brp, 3);
    @(negedge clk);
    chk("t4_oldest_wrap", oldest, 0);
    chk("t4_br_wrap", brp, 0);
    chk("t4_idle", cv, 0);

    // 6: async reset during ST_WAIT
    drive_edge();
    clear_al();
    occ[0] = 1; rdy[0] = 1; iss[0] = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_wait", sreq, 1);
    drive_edge(); rst_n = 0;
    #1;
    chk("t6_sreq_drop", sreq, 0);
    @(negedge clk);
    chk("t6_ptrs_zero", {oldest, brp, lqp, sqp, ftp}, 0);
    chk("t6_count_zero", ccnt, 0);
    chk("t6_no_store_done", sd, 0);
    drive_edge(); rst_n = 1; clear_al();
    @(negedge clk);
    chk("t6_idle_after", sreq, 0);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      drive_edge();
      occ = $urandom | $urandom;
      rdy = $urandom | $urandom;
      isb = '0; isl = '0; iss = '0;
      for (int i = 0; i < AL_SIZE; i++) begin
        case ($urandom_range(0, 3))
          1: isb[i] = 1;
          2: isl[i] = 1;
          3: iss[i] = 1;
          default: ;
        endcase
        recl[i] = 6'($urandom);
      end
      urw = $urandom;
      ack = ($urandom_range(0, 2) == 0);
      bmiss = $urandom_range(0, 1) == 1;
      rst_n = ($urandom_range(0, 199) != 0);
    end
    drive_edge();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
